// File: rtl/sa_autosa_csb2apb.sv
// CSB target to APB3 master bridge: one APB transfer per CSB request, optional response pulse.
// Latency: accept T, SETUP T+1, ACCESS T+2.., response the cycle after completion.
// Backpressure: csb_ready only in IDLE; responses are unthrottled one-cycle pulses.
module sa_autosa_csb2apb #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        pclk,
    input  logic        prstn,
    input  logic        csb_valid,
    output logic        csb_ready,
    input  logic [15:0] csb_addr,
    input  logic [31:0] csb_wdat,
    input  logic        csb_write,
    input  logic        csb_nposted,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_is_write,
    output logic        rsp_error,
    output logic        err_sticky,
    input  logic        err_clr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        nposted_q;
    logic        psel_q, penable_q, pwrite_q;
    logic [31:0] paddr_q, pwdata_q;
    logic        rsp_valid_q, rsp_is_write_q, rsp_error_q;
    logic [31:0] rsp_data_q;
    logic        err_sticky_q, err_sticky_d;

    logic done, xfer_err, sticky_set;

    // A pready in the threshold cycle wins over the timeout.
    assign done       = (state_q == ACCESS) && (pready || (TO_EN && (cnt_q == TO_LAST)));
    assign xfer_err   = pready ? pslverr : 1'b1;
    assign sticky_set = done && pwrite_q && !nposted_q && xfer_err;

    assign err_sticky_d = sticky_set | (err_sticky_q & ~err_clr);

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q        <= IDLE;
            cnt_q          <= 16'd0;
            nposted_q      <= 1'b0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            paddr_q        <= 32'd0;
            pwdata_q       <= 32'd0;
            rsp_valid_q    <= 1'b0;
            rsp_is_write_q <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_data_q     <= 32'd0;
            err_sticky_q   <= 1'b0;
        end else begin
            rsp_valid_q  <= 1'b0;
            err_sticky_q <= err_sticky_d;
            case (state_q)
                IDLE: begin
                    if (csb_valid) begin
                        paddr_q   <= {BASE_ADDR[31:18], csb_addr, 2'b00};
                        pwdata_q  <= csb_write ? csb_wdat : 32'd0;
                        pwrite_q  <= csb_write;
                        nposted_q <= csb_nposted;
                        psel_q    <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= 16'd0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        psel_q         <= 1'b0;
                        penable_q      <= 1'b0;
                        state_q        <= IDLE;
                        rsp_valid_q    <= !pwrite_q || nposted_q;
                        rsp_is_write_q <= pwrite_q;
                        rsp_error_q    <= xfer_err;
                        rsp_data_q     <= (!pwrite_q && !xfer_err) ? prdata : 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign csb_ready    = (state_q == IDLE);
    assign psel         = psel_q;
    assign penable      = penable_q;
    assign pwrite       = pwrite_q;
    assign paddr        = paddr_q;
    assign pwdata       = pwdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_is_write = rsp_is_write_q;
    assign rsp_error    = rsp_error_q;
    assign err_sticky   = err_sticky_q;

endmodule

// File: doc/sa_autosa_csb2apb.md
# sa_autosa_csb2apb

CSB-to-APB bridge: accepts register requests on the AUTOSA CSB target port and executes each one as a single APB3 master transfer. Read data and non-posted write completions are returned on the CSB response port. It sits between the AUTOSA CSB master fabric and legacy APB peripherals, so CSB-addressed registers can live behind an APB bus. Access timeout and slave-error reporting are built in.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, supplies paddr[31:18]; bits [17:0] of BASE_ADDR are ignored.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before forced termination; 0 disables the timeout; 16-bit range.

Ports:
- pclk  in  1  clock; all logic is on the rising edge.
- prstn  in  1  reset, asynchronous, active-low.
- csb_valid  in  1  CSB request valid.
- csb_ready  out  1  CSB request ready.
- csb_addr  in  16  register word address.
- csb_wdat  in  32  write data.
- csb_write  in  1  1 = write, 0 = read.
- csb_nposted  in  1  1 = write requires a completion response.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  read data; 0 for write completions and for errors.
- rsp_is_write  out  1  1 = the response is a write completion.
- rsp_error  out  1  the transfer ended with pslverr or timeout.
- err_sticky  out  1  set by a posted-write error.
- err_clr  in  1  clears err_sticky.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  32  {BASE_ADDR[31:18], captured csb_addr, 2'b00}.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- csb_ready = (state == IDLE). Only the handshake csb_valid & csb_ready accepts a request.
- On accept, capture addr, wdat, write and nposted into registers, then go IDLE -> SETUP. The CSB inputs are don't-care after the accept cycle.
- SETUP: psel=1, penable=0, with paddr, pwrite and pwdata driven from the captured registers. Unconditionally go -> ACCESS.
- ACCESS: psel=1, penable=1. The APB outputs stay stable until completion.
- Completion occurs in the first ACCESS cycle where pready=1. The error flag takes the value of pslverr sampled in that cycle. Next state is IDLE.
- Timeout: a 16-bit counter clears on SETUP and increments on each ACCESS cycle with pready=0.
  - When TIMEOUT_CYCLES≠0, the count equals TIMEOUT_CYCLES-1, and pready=0, the transfer terminates with error=1 and the FSM goes -> IDLE.
  - psel and penable drop in the next cycle.
- Response generation is registered and occurs in the cycle after completion:
  - Read: rsp_valid=1, rsp_is_write=0, rsp_error=err, rsp_data = err ? 0 : prdata captured at completion.
  - Non-posted write: rsp_valid=1, rsp_is_write=1, rsp_data=0, rsp_error=err.
  - Posted write: no rsp_valid. If err=1, set err_sticky.
- err_sticky: err_clr=1 clears it. If a set and a clear happen in the same cycle, the set wins.
- pwdata is driven to 0 for reads.
- There is no response backpressure: rsp_valid is a pulse that the CSB master must sample.

## Timing
- Reset (async, immediate): state=IDLE; psel, penable and pwrite = 0; paddr and pwdata = 0; csb_ready=1; rsp_valid=0; rsp_data=0; rsp_is_write=0; rsp_error=0; err_sticky=0; timeout counter=0.
- If prstn asserts mid-transfer, the APB transfer aborts immediately and no response is issued.
- Accept in cycle T:
  - T+1: SETUP.
  - T+2: ACCESS.
  - Zero-wait completion at T+2 gives rsp_valid at T+3 and csb_ready=1 at T+3.
  - The next accept can occur at T+3, so peak rate is 1 transaction per 3 cycles.
- Each pready wait state adds 1 cycle.
- Timeout with TIMEOUT_CYCLES=N: the last ACCESS cycle is T+1+N, and rsp_valid (if one is due) is at T+2+N.
- A pready=1 arriving in the same cycle as the timeout threshold counts as a normal completion, with pslverr honoured.
- csb_valid while csb_ready=0 is ignored; the master holds the request.

## Test plan
- Zero-wait read: BASE_ADDR=32'h4000_0000, csb_addr=16'h0012, prdata=32'hCAFE_F00D, pready=1 -> paddr=32'h4000_0048, psel at T+1, penable at T+2, rsp_valid at T+3 with rsp_data=32'hCAFE_F00D, rsp_is_write=0, rsp_error=0.
- Non-posted write with 2 wait states, csb_wdat=32'h1234_5678 -> pwdata=32'h1234_5678 held for 3 ACCESS cycles, rsp_valid at T+5, rsp_is_write=1, rsp_error=0.
- Posted write with pslverr=1 -> no rsp_valid, err_sticky=1; err_clr=1 in a later cycle -> err_sticky=0.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 on a read -> penable high for exactly 4 cycles, then psel=0, rsp_valid with rsp_error=1 and rsp_data=0, csb_ready=1.
- Back-to-back: csb_valid held high for 3 requests -> accepts at T, T+3, T+6, with csb_ready=0 during SETUP and ACCESS.
- Reset during ACCESS: prstn=0 -> psel, penable and csb_ready reset immediately, no rsp_valid; after release the next request completes normally.
